// File: rtl/alu_response_checker.sv
// -----------------------------------------------------------------------------
// alu_response_checker
//
// Response-side monitor for the ALU. It watches the operands and control code
// going into the ALU, builds its own expected result/zeroFlag for each sample,
// delays that expectation through a LATENCY-deep pipeline, and compares it with
// the ALU outputs. It keeps check, error and skip counters plus a record of the
// first mismatch.
//
// Parameters:
//   WIDTH    operand/result width
//   LATENCY  ALU cycles from operand sample to valid result (legal 1..4)
//   CNT_W    width of the counters
//
// Ports:
//   clock            rising-edge clock
//   resetN           asynchronous active-low reset
//   enable           checking armed while high
//   readData1/2      ALU operands A and B
//   aluControlCode   ALU control code
//   result/zeroFlag  ALU outputs under check
//   carryBit         ALU carry output (only with ALU_CARRY_CHECK_EN)
//   checkCount       comparisons performed (saturating)
//   errorCount       mismatches seen (saturating)
//   errorFlag        sticky: at least one mismatch
//   firstErrCode     control code of the first mismatch
//   firstErrExpected expected result of the first mismatch
//   skipCount        unsupported codes seen while checking (saturating)
//
// Build option: define ALU_CARRY_CHECK_EN to add carryBit and check the
// carry of add (code 2) and the not-borrow of subtract (code 10).
// -----------------------------------------------------------------------------
module alu_response_checker #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             enable,
    input  logic [WIDTH-1:0] readData1,
    input  logic [WIDTH-1:0] readData2,
    input  logic [3:0]       aluControlCode,
    input  logic [WIDTH-1:0] result,
    input  logic             zeroFlag,
`ifdef ALU_CARRY_CHECK_EN
    input  logic             carryBit,
`endif
    output logic [CNT_W-1:0] checkCount,
    output logic [CNT_W-1:0] errorCount,
    output logic             errorFlag,
    output logic [3:0]       firstErrCode,
    output logic [WIDTH-1:0] firstErrExpected,
    output logic [CNT_W-1:0] skipCount
);

    typedef enum logic [1:0] {IDLE, FILL, CHECK, DRAIN} state_t;

    typedef struct packed {
        logic             supported;
        logic [3:0]       code;
        logic [WIDTH-1:0] exp_result;
        logic             exp_zero;
`ifdef ALU_CARRY_CHECK_EN
        logic             carry_chk;
        logic             exp_carry;
`endif
    } entry_t;

    // FILL lasts LATENCY-1 cycles, DRAIN lasts LATENCY cycles.
    localparam logic [1:0]       FILL_LAST  = 2'((LATENCY > 1) ? LATENCY - 2 : 0);
    localparam logic [1:0]       DRAIN_LAST = 2'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t             state_q, state_d;
    logic [1:0]         phase_q, phase_d;
    logic [LATENCY-1:0] valid_q;
    entry_t             pipe_q [LATENCY];
    entry_t             ref_entry;
    entry_t             tail;
    logic               compare_en;
    logic               mismatch;

    logic [CNT_W-1:0]   check_count_q, check_count_d;
    logic [CNT_W-1:0]   error_count_q, error_count_d;
    logic [CNT_W-1:0]   skip_count_q,  skip_count_d;
    logic               error_flag_q,  error_flag_d;
    logic [3:0]         first_code_q,  first_code_d;
    logic [WIDTH-1:0]   first_exp_q,   first_exp_d;

    // ---------------------------------------------------------------- reference
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        ref_entry           = '0;
        ref_entry.supported = 1'b1;
        ref_entry.code      = aluControlCode;
        case (aluControlCode)
            4'd2: begin
`ifdef ALU_CARRY_CHECK_EN
                {ref_entry.exp_carry, ref_entry.exp_result} =
                    {1'b0, readData1} + {1'b0, readData2};
                ref_entry.carry_chk = 1'b1;
`else
                ref_entry.exp_result = readData1 + readData2;
`endif
            end
            4'd10: begin
                ref_entry.exp_result = readData1 - readData2;
`ifdef ALU_CARRY_CHECK_EN
                ref_entry.exp_carry = (readData1 >= readData2);
                ref_entry.carry_chk = 1'b1;
`endif
            end
            4'd6:       ref_entry.exp_result = readData1 & readData2;
            4'd4:       ref_entry.exp_result = readData1 | readData2;
            4'd9:       ref_entry.exp_result = readData1 ^ readData2;
            4'd5:       ref_entry.exp_result = ~(readData1 | readData2);
            4'd12:      ref_entry.exp_result = ~(readData1 & readData2);
            4'd13, 4'd7: ref_entry.exp_result = readData2;
            default:    ref_entry.supported = 1'b0;
        endcase
        ref_entry.exp_zero = (ref_entry.exp_result == '0);
    end

    // ---------------------------------------------------------------- pipeline
    // IDLE clears every stage behind stage 0 so a quick re-enable never sees
    // stale entries from an aborted FILL.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= enable;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= (state_q == IDLE) ? 1'b0 : valid_q[i-1];
            end
        end
    end

    // NOTE: payload registers are not reset; the valid bits alone qualify them.
    always_ff @(posedge clock) begin
        pipe_q[0] <= ref_entry;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign tail       = pipe_q[LATENCY-1];
    assign compare_en = valid_q[LATENCY-1] && ((state_q == CHECK) || (state_q == DRAIN));
`ifdef ALU_CARRY_CHECK_EN
    assign mismatch = (result != tail.exp_result) || (zeroFlag != tail.exp_zero) ||
                      (tail.carry_chk && (carryBit != tail.exp_carry));
`else
    assign mismatch = (result != tail.exp_result) || (zeroFlag != tail.exp_zero);
`endif

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    phase_d = 2'd0;
                    state_d = (LATENCY > 1) ? FILL : CHECK;
                end
            end
            FILL: begin
                if (!enable)                  state_d = IDLE;
                else if (phase_q == FILL_LAST) state_d = CHECK;
                else                          phase_d = phase_q + 2'd1;
            end
            CHECK: begin
                if (!enable) begin
                    state_d = DRAIN;
                    phase_d = 2'd0;
                end
            end
            DRAIN: begin
                // Re-enable resumes checking with the in-flight entries intact.
                if (enable)                     state_d = CHECK;
                else if (phase_q == DRAIN_LAST) state_d = IDLE;
                else                            phase_d = phase_q + 2'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- counters
    always_comb begin
        check_count_d = check_count_q;
        error_count_d = error_count_q;
        skip_count_d  = skip_count_q;
        error_flag_d  = error_flag_q;
        first_code_d  = first_code_q;
        first_exp_d   = first_exp_q;
        if (compare_en) begin
            if (tail.supported) begin
                if (check_count_q != CNT_MAX) check_count_d = check_count_q + 1'b1;
                if (mismatch) begin
                    if (error_count_q != CNT_MAX) error_count_d = error_count_q + 1'b1;
                    error_flag_d = 1'b1;
                    // Capture only while the flag is still clear: first mismatch wins.
                    if (!error_flag_q) begin
                        first_code_d = tail.code;
                        first_exp_d  = tail.exp_result;
                    end
                end
            end else if (skip_count_q != CNT_MAX) begin
                skip_count_d = skip_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q       <= IDLE;
            phase_q       <= 2'd0;
            check_count_q <= '0;
            error_count_q <= '0;
            skip_count_q  <= '0;
            error_flag_q  <= 1'b0;
            first_code_q  <= '0;
            first_exp_q   <= '0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            check_count_q <= check_count_d;
            error_count_q <= error_count_d;
            skip_count_q  <= skip_count_d;
            error_flag_q  <= error_flag_d;
            first_code_q  <= first_code_d;
            first_exp_q   <= first_exp_d;
        end
    end

    assign checkCount       = check_count_q;
    assign errorCount       = error_count_q;
    assign skipCount        = skip_count_q;
    assign errorFlag        = error_flag_q;
    assign firstErrCode     = first_code_q;
    assign firstErrExpected = first_exp_q;

endmodule
